// File: rtl/addsub_pkg.sv
// addsub_pkg: shared width, op encodings and FSM states for the addsub accumulator
package addsub_pkg;
    localparam int WIDTH = 4;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    typedef enum logic {ST_IDLE, ST_RESP} state_t;
endpackage

// File: rtl/addsub_accumulator_if.sv
// addsub_accumulator_if: operation stream in, registered result stream out
interface addsub_accumulator_if #(
    parameter int CNT_W = 8
);
    logic in_valid;
    logic in_ready;
    logic [1:0] in_op;
    logic [addsub_pkg::WIDTH-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [addsub_pkg::WIDTH-1:0] acc;
    logic out_co;
    logic out_v;
    logic ovf_sticky;
    logic ovf_clr;
    logic [CNT_W-1:0] op_count;
    modport master (
        output in_valid, in_op, in_data, out_ready, ovf_clr,
        input in_ready, out_valid, acc, out_co, out_v, ovf_sticky, op_count
    );
    modport slave (
        input in_valid, in_op, in_data, out_ready, ovf_clr,
        output in_ready, out_valid, acc, out_co, out_v, ovf_sticky, op_count
    );
endinterface

// File: rtl/addsub.sv
// addsub: 4-bit adder/subtractor, S = A + (B ^ M) + M with carry and signed overflow
module addsub (
    input logic [addsub_pkg::WIDTH-1:0] A,
    input logic [addsub_pkg::WIDTH-1:0] B,
    input logic M,
    output logic [addsub_pkg::WIDTH-1:0] S,
    output logic Co,
    output logic V
);
    localparam int W = addsub_pkg::WIDTH;
    logic [W-1:0] bx;
    assign bx = B ^ {W{M}};
    assign {Co, S} = {1'b0, A} + {1'b0, bx} + {{W{1'b0}}, M};
    assign V = (A[W-1] == bx[W-1]) & (S[W-1] != A[W-1]);
endmodule

// File: rtl/addsub_accumulator.sv
// addsub_accumulator: valid/ready accumulator wrapped around the addsub datapath
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    addsub_accumulator_if.slave bus
);
    state_t state, state_n;
    logic accept, arith, s_co, s_v, co_q, v_q, sticky_q;
    logic [WIDTH-1:0] s_sum, acc_q;
    logic [CNT_W-1:0] cnt_q;
    assign bus.in_ready = rst_n & ((state == ST_IDLE) | bus.out_ready);
    assign accept = bus.in_valid & bus.in_ready;
    assign arith = ~bus.in_op[1];
    addsub u_addsub (
        .A(acc_q),
        .B(bus.in_data),
        .M(bus.in_op[0]),
        .S(s_sum),
        .Co(s_co),
        .V(s_v)
    );
    // RESP holds until the result is consumed; an accept always lands a fresh result
    always_comb begin
        state_n = state;
        state_n = accept ? ST_RESP : (bus.out_ready ? ST_IDLE : state);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_n;
    end
    // result registers and counter update only on an accepted op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            co_q <= 1'b0;
            v_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= arith ? s_sum : (bus.in_op[0] ? '0 : bus.in_data);
            co_q <= arith & s_co;
            v_q <= arith & s_v;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
    // sticky overflow: a new overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else sticky_q <= (accept & arith & s_v) | (sticky_q & ~bus.ovf_clr);
    end
    assign bus.out_valid = (state == ST_RESP);
    assign bus.acc = acc_q;
    assign bus.out_co = co_q;
    assign bus.out_v = v_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.op_count = cnt_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// tb_addsub_accumulator: directed table, corner sequences and random stream against an arithmetic model
module tb_addsub_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int m_acc, m_co, m_v, m_sticky, m_cnt;
    typedef struct {
        logic [1:0] op;
        int data;
        int acc;
        int co;
        int v;
    } vec_t;
    vec_t tbl[8];
    addsub_accumulator_if #(.CNT_W(8)) bus();
    addsub_accumulator #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sgn(input int x);
        return x > 7 ? x - 16 : x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_co = 0; m_v = 0; m_sticky = 0; m_cnt = 0;
    endtask

    task automatic model_apply(input logic [1:0] op, input int d, input bit clr);
        int r;
        m_co = 0; m_v = 0;
        if (op == 2'b00) begin
            m_co = (m_acc + d) > 15;
            r = sgn(m_acc) + sgn(d);
            m_v = (r > 7 || r < -8);
            m_acc = (m_acc + d) % 16;
        end else if (op == 2'b01) begin
            m_co = m_acc >= d;
            r = sgn(m_acc) - sgn(d);
            m_v = (r > 7 || r < -8);
            m_acc = (m_acc + 16 - d) % 16;
        end else if (op == 2'b10) m_acc = d;
        else m_acc = 0;
        m_sticky = m_v | (m_sticky & !clr);
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " acc"}, int'(bus.acc), m_acc);
        chk({tag, " co"}, int'(bus.out_co), m_co);
        chk({tag, " v"}, int'(bus.out_v), m_v);
        chk({tag, " sticky"}, int'(bus.ovf_sticky), m_sticky);
        chk({tag, " count"}, int'(bus.op_count), m_cnt);
        chk({tag, " out_valid"}, int'(bus.out_valid), 1);
    endtask

    task automatic do_op(input logic [1:0] op, input int d, input bit clr);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_data = 4'(d);
        bus.out_ready = 1'b1;
        bus.ovf_clr = clr;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        if (!bus.in_ready) chk("in_ready timeout", 0, 1);
        step();
        bus.in_valid = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.in_data = 4'($urandom_range(15));
        model_apply(op, d, clr);
    endtask

    initial begin
        int a0;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_data = 4'd0;
        bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        model_reset();
        tbl[0] = '{2'b10, 7, 7, 0, 0};
        tbl[1] = '{2'b00, 1, 8, 0, 1};
        tbl[2] = '{2'b10, 3, 3, 0, 0};
        tbl[3] = '{2'b01, 5, 14, 0, 0};
        tbl[4] = '{2'b10, 5, 5, 0, 0};
        tbl[5] = '{2'b01, 3, 2, 1, 0};
        tbl[6] = '{2'b10, 15, 15, 0, 0};
        tbl[7] = '{2'b00, 1, 0, 1, 0};
        #12;
        chk("reset in_ready", int'(bus.in_ready), 0);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset acc", int'(bus.acc), 0);
        chk("reset count", int'(bus.op_count), 0);
        chk("reset sticky", int'(bus.ovf_sticky), 0);
        rst_n = 1'b1;
        #1;
        chk("idle in_ready", int'(bus.in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].op, tbl[i].data, 1'b0);
            chk($sformatf("tbl%0d acc", i), int'(bus.acc), tbl[i].acc);
            chk($sformatf("tbl%0d co", i), int'(bus.out_co), tbl[i].co);
            chk($sformatf("tbl%0d v", i), int'(bus.out_v), tbl[i].v);
            if (i == 1) begin
                chk("tbl1 sticky", int'(bus.ovf_sticky), 1);
                chk("tbl1 count", int'(bus.op_count), 2);
            end
            if (i == 7) chk("tbl7 sticky kept", int'(bus.ovf_sticky), 1);
        end
        bus.out_ready = 1'b1;
        step();
        chk("drain out_valid", int'(bus.out_valid), 0);
        // backpressure
        do_op(2'b00, 1, 1'b0);
        a0 = m_acc;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_data = 4'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall out_valid", int'(bus.out_valid), 1);
            chk("stall in_ready", int'(bus.in_ready), 0);
            chk("stall acc", int'(bus.acc), a0);
            chk("stall co", int'(bus.out_co), m_co);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release in_ready", int'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        model_apply(2'b00, 2, 1'b0);
        check_all("after stall");
        // sticky set beats clear
        do_op(2'b10, 7, 1'b0);
        do_op(2'b00, 1, 1'b1);
        chk("set+clr sticky", int'(bus.ovf_sticky), 1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        m_sticky = 0;
        chk("clr sticky", int'(bus.ovf_sticky), 0);
        // async reset mid-RESP
        do_op(2'b10, 6, 1'b0);
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst acc", int'(bus.acc), 0);
        chk("async rst out_valid", int'(bus.out_valid), 0);
        chk("async rst count", int'(bus.op_count), 0);
        chk("async rst in_ready", int'(bus.in_ready), 0);
        model_reset();
        #3;
        rst_n = 1'b1;
        #1;
        chk("post rst in_ready", int'(bus.in_ready), 1);
        do_op(2'b10, 9, 1'b0);
        check_all("post rst op");
        // random stream: 255 more ops brings the counter to 256 -> 0
        for (int i = 0; i < 255; i++) begin
            if ($urandom_range(3) == 0) begin
                bus.out_ready = 1'b1;
                bus.in_op = 2'($urandom_range(3));
                step();
            end
            do_op(2'($urandom_range(3)), int'($urandom_range(15)), $urandom_range(7) == 0);
            check_all("rand");
        end
        chk("count wrap", int'(bus.op_count), 0);
        // exhaustive sweep
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    do_op(2'b10, a, 1'b0);
                    do_op(2'(m), b, 1'b0);
                    chk($sformatf("sweep m%0d %0d,%0d sum", m, a, b), int'({bus.out_co, bus.acc}), m_co * 16 + m_acc);
                    chk($sformatf("sweep m%0d %0d,%0d v", m, a, b), int'(bus.out_v), m_v);
                end
        chk("sweep sticky", int'(bus.ovf_sticky), m_sticky);
        chk("sweep count", int'(bus.op_count), m_cnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Upstream driver and result register around the existing 4-bit `addsub` (A/B/M in; S/Co/V out).
- Accepts a stream of operations over a valid/ready handshake.
- Keeps a 4-bit accumulator that feeds `addsub` port A. The incoming operand feeds port B.
- Registers S/Co/V and presents them downstream over a second valid/ready handshake, with a sticky overflow flag and an operation counter.

Parameters:
- WIDTH, 4: operand/accumulator width. Fixed at 4 to match `addsub`; any other value is unsupported.
- CNT_W, 8: width of the accepted-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  block can accept an operation this cycle
- in_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- in_data  in  WIDTH  operand B (ignored for CLEAR)
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  downstream consumes result
- acc  out  WIDTH  accumulator value, which is also the result
- out_co  out  1  registered carry out
- out_v  out  1  registered signed overflow
- ovf_sticky  out  1  set by any accepted op that produced V=1
- ovf_clr  in  1  synchronous clear of ovf_sticky
- op_count  out  CNT_W  number of accepted operations, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, out_co=0, out_v=0, out_valid=0, ovf_sticky=0, op_count=0. in_ready=0 while rst_n=0.
- FSM states:
  - IDLE: out_valid=0, in_ready=1.
  - RESP: out_valid=1, in_ready=out_ready.
- Accept means in_valid & in_ready at a rising edge.
- On accept, all of the following happen at the same edge:
  - State goes to RESP; op_count increments (2^CNT_W-1 wraps to 0).
  - ADD/SUB: `addsub` is driven with A=acc, B=in_data, M=in_op[0]. acc<=S, out_co<=Co, out_v<=V.
  - LOAD: acc<=in_data, out_co<=0, out_v<=0.
  - CLEAR: acc<=0, out_co<=0, out_v<=0. CLEAR does not touch ovf_sticky.
- Latency: one cycle. The result is visible with out_valid=1 in the cycle after the accepting edge.
- RESP transitions:
  - out_ready=1 with accept: stay in RESP with the new result (back-to-back, one op per cycle).
  - out_ready=1 without accept: go to IDLE.
  - out_ready=0: hold. acc, out_co and out_v stay stable and in_ready=0.
- Subtraction semantics follow `addsub`: S = A + ~B + 1. Co=1 means no borrow (A >= B unsigned). V = signed two's-complement overflow.
- ovf_sticky:
  - Set at an accepting edge whose op produced V=1.
  - Cleared by ovf_clr=1 at an edge.
  - Set and clear in the same cycle: set wins.
- in_data and in_op are don't-care when in_valid=0. `addsub` outputs are not observed unless an ADD/SUB is accepted.
- Reset asserted mid-RESP: an undelivered result is discarded. All outputs return to reset values immediately, asynchronously.
- No combinational path from in_valid/in_data to any output. in_ready depends combinationally only on state and out_ready.

Decomposition:
- Shared package `addsub_pkg`:
  - WIDTH constant (4).
  - Op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_LOAD=2'b10, OP_CLEAR=2'b11.
  - FSM state encoding ST_IDLE, ST_RESP.
- One sub-module: the existing `addsub`, instantiated once as the datapath. No other sub-modules.

Test Plan:
- LOAD 7, then ADD 1, out_ready=1 → acc=4'b1000, out_co=0, out_v=1, ovf_sticky=1, op_count=2.
- LOAD 3, SUB 5 → acc=4'b1110, out_co=0, out_v=0. Then LOAD 5, SUB 3 → acc=4'b0010, out_co=1, out_v=0.
- LOAD 15, ADD 1 → acc=0, out_co=1, out_v=0, ovf_sticky unchanged.
- Backpressure:
  - Stimulus: accept ADD, out_ready=0 for 3 cycles while in_valid=1.
  - Expected during stall: out_valid=1, in_ready=0, acc/out_co/out_v stable.
  - On out_ready=1: next op accepted in the same cycle.
- Sticky flag and counter:
  - Overflowing ADD accepted in the same cycle as ovf_clr=1 → ovf_sticky=1.
  - ovf_clr alone on the next cycle → ovf_sticky=0.
  - 256 accepted ops → op_count wraps to 0.
- Reset: drop rst_n mid-RESP (out_ready=0) → acc=0, out_valid=0, op_count=0 without waiting for clk. After release, first accept is back in IDLE behaviour.
- Exhaustive sweep: for M in {0,1}, all 16×16 pairs via LOAD a / op b → {out_co,acc} and out_v match the `addsub` golden model.
